// File: rtl/note_lut_arb.sv
// Round-robin arbiter that time-shares one note2cnt lookup table among NV voices.
// One lookup at a time: IDLE -> LOOKUP (LAT+1 cycles) -> DONE (ack pulse) -> IDLE.
module note_lut_arb #(
  parameter int NV  = 4,
  parameter int BW  = 16,
  parameter int LAT = 1
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [NV-1:0]      req_i,
  input  logic [NV*8-1:0]    note_i,
  output logic [NV-1:0]      ack_o,
  output logic [NV*BW-1:0]   halfCntPeriod_o,
  output logic [NV-1:0]      valid_o,
  output logic [7:0]         lut_note_o,
  input  logic [BW-1:0]      lut_halfCntPeriod_i,
  output logic               busy_o
);

  localparam int          IW      = $clog2(NV);
  localparam int unsigned NVU     = NV;
  localparam logic [2:0]  LAT_CNT = 3'(LAT);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic [IW-1:0] rr_pick;
  logic [IW-1:0] cand;
  logic          rr_found;
  logic [2:0]    wait_cnt;
  logic          grant;
  logic          finish;

  logic [7:0]    notes [NV];
  logic [BW-1:0] slot  [NV];

  for (genvar g = 0; g < NV; g++) begin : g_unpack
    assign notes[g]                      = note_i[8*g +: 8];
    assign halfCntPeriod_o[BW*g +: BW]   = slot[g];
  end

  // First requester at or after last_grant+1, wrapping modulo NV.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NVU; k++) begin
      cand = IW'((32'(last_grant) + k) % NVU);
      if (!rr_found && req_i[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign grant  = (state == IDLE) && (|req_i);
  assign finish = (state == LOOKUP) && (wait_cnt == LAT_CNT);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_i) state_nxt = LOOKUP;
      LOOKUP:  if (wait_cnt == LAT_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lut_note_o only loads at a grant edge, so the shared LUT input never glitches.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      ack_o      <= '0;
      valid_o    <= '0;
      lut_note_o <= '0;
      last_grant <= IW'(NV - 1);
      winner     <= '0;
      wait_cnt   <= '0;
      for (int unsigned v = 0; v < NVU; v++) begin
        slot[v] <= '0;
      end
    end else begin
      ack_o <= '0;
      if (grant) begin
        winner     <= rr_pick;
        last_grant <= rr_pick;
        lut_note_o <= notes[rr_pick];
        wait_cnt   <= '0;
      end else if (state == LOOKUP) begin
        if (finish) begin
          slot[winner]    <= lut_halfCntPeriod_i;
          valid_o[winner] <= 1'b1;
          ack_o[winner]   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
    end
  end

endmodule
